// File: rtl/regfile_write_buffer_pkg.sv
// ============================================================================
// regfile_write_buffer_pkg : shared widths and buffer entry type
// Revision: 1.0
// ============================================================================
`default_nettype none

package regfile_write_buffer_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] adrx;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/regfile_write_buffer_bypass.sv
// ============================================================================
// wb_bypass_match : finds the youngest valid buffer entry matching a read address
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_bypass_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = regfile_write_buffer_pkg::ADDR_W,
  parameter int DATA_W = regfile_write_buffer_pkg::DATA_W
) (
  input  logic [ADDR_W-1:0]        rd_adrx,
  input  logic [DEPTH-1:0]         entry_valid,
  input  logic [ADDR_W-1:0]        entry_adrx [DEPTH],
  input  logic [DATA_W-1:0]        entry_data [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  output logic                     hit,
  output logic [DATA_W-1:0]        data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to youngest from the head so the last match seen is the newest.
  always_comb begin
    hit   = 1'b0;
    data  = '0;
    w_idx = head;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = head + PTR_W'(k);
      if (entry_valid[w_idx] && (entry_adrx[w_idx] == rd_adrx)) begin
        hit  = 1'b1;
        data = entry_data[w_idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_write_buffer.sv
// ============================================================================
// regfile_write_buffer : in-order write queue ahead of the register file write
//                        port, with read bypass for both read ports
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_write_buffer #(
  parameter int DEPTH        = 4,
  parameter int DATA_W       = regfile_write_buffer_pkg::DATA_W,
  parameter int ADDR_W       = regfile_write_buffer_pkg::ADDR_W,
  parameter int ZERO_DISCARD = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [ADDR_W-1:0]        inAdrx,
  input  logic [DATA_W-1:0]        inData,
  input  logic                     stall,
  output logic                     writeEn,
  output logic [ADDR_W-1:0]        writeAdrx,
  output logic [DATA_W-1:0]        writeData,
  input  logic [ADDR_W-1:0]        rdAdrx0,
  input  logic [ADDR_W-1:0]        rdAdrx1,
  output logic                     hit0,
  output logic                     hit1,
  output logic [DATA_W-1:0]        bypassData0,
  output logic [DATA_W-1:0]        bypassData1,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] adrx;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           r_entries [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_zero_drop;
  entry_t            w_head_entry;
  logic [DEPTH-1:0]  w_valid;
  logic [ADDR_W-1:0] w_adrx [DEPTH];
  logic [DATA_W-1:0] w_data [DEPTH];

  assign empty   = (r_count == '0);
  assign full    = (r_count == CNT_W'(DEPTH));
  assign count   = r_count;
  // Push is blocked when full even if a pop happens, keeping inReady registered.
  assign inReady = !full;

  assign w_zero_drop = (ZERO_DISCARD != 0) && (inAdrx == '0);
  assign w_push      = inValid && inReady && !w_zero_drop;
  assign w_pop       = !empty && !stall;

  assign w_head_entry = r_entries[r_head];
  assign writeEn      = w_pop;
  assign writeAdrx    = w_head_entry.valid ? w_head_entry.adrx : '0;
  assign writeData    = w_head_entry.valid ? w_head_entry.data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_entries[r_head].valid <= 1'b0;
        r_head                  <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_entries[r_tail] <= '{valid: 1'b1, adrx: inAdrx, data: inData};
        r_tail            <= r_tail + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_unpack
      assign w_valid[g] = r_entries[g].valid;
      assign w_adrx[g]  = r_entries[g].adrx;
      assign w_data[g]  = r_entries[g].data;
    end
  endgenerate

  wb_bypass_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_match0 (
    .rd_adrx     (rdAdrx0),
    .entry_valid (w_valid),
    .entry_adrx  (w_adrx),
    .entry_data  (w_data),
    .head        (r_head),
    .hit         (hit0),
    .data        (bypassData0)
  );

  wb_bypass_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_match1 (
    .rd_adrx     (rdAdrx1),
    .entry_valid (w_valid),
    .entry_adrx  (w_adrx),
    .entry_data  (w_data),
    .head        (r_head),
    .hit         (hit1),
    .data        (bypassData1)
  );

endmodule

`default_nettype wire

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
- Small in-order write queue directly upstream of the 32x32 register file's single write port.
- Accepts (address, data) writes from the writeback producers and drains at most one entry per cycle into the register file's writeEn/writeAdrx/writeData.
- Provides read bypass for both register-file read ports, so a read of an address still held in the buffer returns the newest buffered value.

Parameters:
- DEPTH, 4, number of buffered entries (power of 2, >=2)
- DATA_W, 32, data width
- ADDR_W, 5, register address width
- ZERO_DISCARD, 1, if 1, writes to address 0 are accepted but never enqueued

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- inValid  in  1  producer has a write
- inReady  out  1  buffer can accept this cycle
- inAdrx  in  ADDR_W  write address
- inData  in  DATA_W  write data
- stall  in  1  register file write port unavailable this cycle
- writeEn  out  1  to register file
- writeAdrx  out  ADDR_W  to register file
- writeData  out  DATA_W  to register file
- rdAdrx0  in  ADDR_W  read address, port 0 (same signal driving the register file)
- rdAdrx1  in  ADDR_W  read address, port 1
- hit0  out  1  buffered value exists for rdAdrx0
- hit1  out  1  buffered value exists for rdAdrx1
- bypassData0  out  DATA_W  newest buffered data for rdAdrx0
- bypassData1  out  DATA_W  newest buffered data for rdAdrx1
- count  out  clog2(DEPTH)+1  occupancy
- full  out  1  count==DEPTH
- empty  out  1  count==0

Behaviour:
- Reset (asynchronous, rst_n low):
  - Head pointer, tail pointer and count go to 0; all entry valid bits clear.
  - Outputs: writeEn=0, empty=1, full=0, inReady=1, hit0/hit1=0.
  - writeAdrx, writeData, bypassData0 and bypassData1 are 0, because outputs are masked when not valid.
- Reset mid-operation: all buffered writes are lost. No write is issued on the reset cycle.
- Push and pop conditions:
  - push = inValid && inReady && !(ZERO_DISCARD && inAdrx==0)
  - inReady = !full. It depends only on registered state; there is no combinational path from stall.
  - pop = writeEn = !empty && !stall
- Write output: writeAdrx/writeData present the head entry combinationally from registered state. The register file commits on the same edge that pops the entry, so latency is 1 edge from push to earliest commit.
- Discarded zero-address write: the handshake completes (inReady=1) but count is unchanged.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - When full, push is blocked even if a pop occurs in the same cycle. This is a deliberate choice that keeps inReady registered.
- Pointer wrap-around: pointers are modulo DEPTH. count distinguishes full from empty.
- Ordering: strict FIFO, no coalescing. Two writes to the same address both commit, in order.
- Bypass (combinational, per port):
  - Compare rdAdrx against all valid entries.
  - hit = any match. bypassData = data of the youngest matching entry (closest to the tail); 0 if there is no hit.
  - Address 0 never hits when ZERO_DISCARD=1.
  - The head entry being committed this cycle still counts as a hit, because the register file read sees the old value until after the edge.
  - The incoming inData in the push cycle is NOT bypassed; it becomes visible the cycle after the push.
- stall held high: the buffer fills to DEPTH, then inReady=0. Nothing is lost and writeEn stays 0.
- Consumer mux (outside this block): rdData = hit ? bypassData : registerFile rdData.

Decomposition:
- Shared package:
  - ADDR_W, DATA_W and NUM_REGS=32.
  - A wb_entry_t typedef holding valid, adrx[ADDR_W] and data[DATA_W].
- One natural sub-module, wb_bypass_match:
  - Takes an address plus the entry array with the head/tail pointers.
  - Returns hit and youngest-match data.
  - Instantiated once per read port.

Test Plan:
1. Reset then idle: with rst_n=0 asserted mid-run while count=3, the next cycle shows count=0, empty=1, writeEn=0, and no further writes reach the register file.
2. Back-to-back fill without stall: push adrx 1..8 with data 0x11..0x88, one per cycle.
   - The register file receives adrx 1..8 in order.
   - count never exceeds 1 and inReady stays 1.
3. Stall fill and full:
   - With stall=1, push 5 writes (adrx 3,4,5,6,7). After 4 pushes, full=1 and inReady=0, so the 5th is held.
   - Release stall: 4 commits in order, then the 5th is accepted.
4. Bypass youngest match:
   - With stall=1, push (adrx 9, 0xA), then (adrx 9, 0xB).
   - rdAdrx0=9 gives hit0=1, bypassData0=0xB. rdAdrx1=10 gives hit1=0.
   - After draining, hit0=0 and the register file reg 9 holds 0xB.
5. Zero discard: push (adrx 0, 0xDEAD) -> inReady=1, count stays 0, writeEn never asserts, and rdAdrx0=0 gives hit0=0.
6. Wrap-around plus simultaneous push/pop: run 3*DEPTH pushes with stall toggling every other cycle.
   - count matches the model every cycle.
   - The commit order matches the push order.
   - bypassData matches the reference model every cycle.
